// File: rtl/apb_rd_sequencer.sv
// APB3 read master: on start, reads P_NUM_WORDS consecutive words from P_BASE
// into a local result buffer, reporting slave errors and ready timeouts.
module apb_rd_sequencer #(
  parameter logic [31:0] P_BASE      = 32'h7000_0000,
  parameter int          P_NUM_WORDS = 4,
  parameter int          P_TIMEOUT   = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        timeout,
  output logic        psel,
  output logic        penable,
  output logic [31:0] paddr,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data
);

  localparam int         CW       = $clog2(P_TIMEOUT + 1);
  localparam logic [3:0] LAST_IDX = 4'(P_NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_FIN} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      idx_reg, idx_next;
  logic [CW-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic            err_reg, err_next;
  logic            timeout_reg, timeout_next;
  logic [31:0]     paddr_reg, paddr_next;
  logic            capture;

  logic [31:0]     buf_reg [P_NUM_WORDS];
  logic [31:0]     rd_view [16];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      paddr_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= err_next;
      timeout_reg <= timeout_next;
      paddr_reg   <= paddr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    tmo_cnt_next = tmo_cnt_reg;
    err_next     = err_reg;
    timeout_next = timeout_reg;
    paddr_next   = paddr_reg;
    capture      = 1'b0;
    psel         = 1'b0;
    penable      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_SETUP;
          err_next     = 1'b0;
          timeout_next = 1'b0;
          idx_next     = '0;
          paddr_next   = P_BASE;
        end
      end
      S_SETUP: begin
        psel         = 1'b1;
        busy         = 1'b1;
        tmo_cnt_next = '0;
        state_next   = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        busy    = 1'b1;
        if (pready) begin
          capture = 1'b1;
          if (pslverr) err_next = 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = S_FIN;
          end else begin
            // Address for the next word is registered here so it is valid throughout SETUP.
            idx_next   = idx_reg + 4'd1;
            paddr_next = P_BASE + 32'(idx_reg) + 32'd1;
            state_next = S_SETUP;
          end
        end else if (tmo_cnt_reg == CW'(P_TIMEOUT - 1)) begin
          err_next     = 1'b1;
          timeout_next = 1'b1;
          state_next   = S_FIN;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < P_NUM_WORDS; gi++) begin : g_buf
      always_ff @(posedge pclk or posedge preset) begin
        if (preset)
          buf_reg[gi] <= '0;
        else if (capture && idx_reg == 4'(gi))
          buf_reg[gi] <= prdata;
      end
    end
    // Indices beyond the configured run length read back as zero.
    for (gi = 0; gi < 16; gi++) begin : g_view
      if (gi < P_NUM_WORDS) begin : g_used
        assign rd_view[gi] = buf_reg[gi];
      end else begin : g_unused
        assign rd_view[gi] = '0;
      end
    end
  endgenerate

  assign rd_data = rd_view[rd_idx];
  assign paddr   = paddr_reg;
  assign err     = err_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_apb_rd_sequencer.sv
// Scoreboard bench for apb_rd_sequencer: a behavioural slave plus a run-level
// reference model predicting transfer addresses, status, latency and buffer.
module tb_apb_rd_sequencer;

  localparam logic [31:0] BASE = 32'h7000_0000;
  localparam int          N    = 4;
  localparam int          T    = 16;

  logic        pclk, preset, start, busy, done, err, timeout, psel, penable;
  logic [31:0] paddr, prdata, rd_data;
  logic        pready, pslverr;
  logic [3:0]  rd_idx;

  apb_rd_sequencer #(.P_BASE(BASE), .P_NUM_WORDS(N), .P_TIMEOUT(T)) dut (
    .pclk(pclk), .preset(preset), .start(start), .busy(busy), .done(done),
    .err(err), .timeout(timeout), .psel(psel), .penable(penable), .paddr(paddr),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .rd_idx(rd_idx),
    .rd_data(rd_data)
  );

  typedef struct packed {
    logic               err;
    logic               tmo;
    logic [31:0]        cyc;
    logic [15:0][31:0]  b;
  } res_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  logic [31:0] addr_q[$];
  res_t        res_q[$];

  int          waits [16];
  bit          slverr[16];
  logic [31:0] mem   [16];
  int          hang_idx;
  logic [31:0] model_buf[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    pclk = 1'b0;
    forever #10 pclk = ~pclk;
  end

  initial begin
    cyc = 0;
    forever @(posedge pclk) cyc++;
  end

  // Slave: ready after waits[i] stall cycles, never for hang_idx; junk data while stalling.
  initial begin
    int acc_cnt;
    int si;
    logic [31:0] off;
    acc_cnt = 0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset || !(psel && penable)) begin
        pready = 1'b0; pslverr = 1'b0; prdata = '0; acc_cnt = 0;
      end else begin
        off = paddr - BASE;
        si  = int'(off[3:0]);
        if (si != hang_idx && acc_cnt >= waits[si]) begin
          pready = 1'b1; prdata = mem[si]; pslverr = slverr[si]; acc_cnt = 0;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1)); acc_cnt++;
        end
      end
    end
  end

  // Monitor: protocol rules every cycle, transfer addresses and run results from the queues.
  initial begin
    logic        prev_psel;
    logic [31:0] prev_paddr;
    logic [31:0] ea;
    res_t        r;
    int          rlist[6];
    rlist = '{0, 1, 2, 3, 4, 15};
    prev_psel = 1'b0; prev_paddr = '0; rd_idx = '0;
    forever begin
      @(negedge pclk);
      #2;
      if (preset) begin
        prev_psel = 1'b0;
      end else begin
        if (penable) chk("penable_needs_psel", psel, 1'b1);
        if (psel && penable && prev_psel) chk("paddr_stable", paddr, prev_paddr);
        if (psel) chk("busy_in_xfer", busy, 1'b1);
        if (psel && penable && pready) begin
          if (addr_q.size() == 0) begin
            chk("unexpected_xfer", paddr, 32'hxxxx_xxxx);
          end else begin
            ea = addr_q.pop_front();
            chk("xfer_addr", paddr, ea);
            $display("xfer  addr=%h data=%h slverr=%0b cyc=%0d", paddr, prdata, pslverr, cyc);
          end
        end
        if (done) begin
          chk("fin_busy", busy, 1'b0);
          chk("fin_psel", psel, 1'b0);
          if (res_q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
          end else begin
            r = res_q.pop_front();
            chk("done_err", err, r.err);
            chk("done_timeout", timeout, r.tmo);
            chk("done_cycle", cyc, r.cyc);
            for (int k = 0; k < 6; k++) begin
              rd_idx = 4'(rlist[k]);
              #1;
              chk($sformatf("rd_data[%0d]", rlist[k]), rd_data, r.b[rlist[k]]);
            end
            $display("done  err=%0b timeout=%0b cyc=%0d buf=%h %h %h %h",
                     err, timeout, cyc, r.b[0], r.b[1], r.b[2], r.b[3]);
          end
        end
        prev_psel  = psel;
        prev_paddr = paddr;
      end
    end
  end

  task automatic cfg_clear();
    for (int i = 0; i < 16; i++) begin
      waits[i] = 0; slverr[i] = 1'b0; mem[i] = $urandom;
    end
    hang_idx = -1;
  endtask

  // Reference model for one run, derived from the run-level rules.
  task automatic predict(input int c0);
    res_t r;
    int   lat;
    lat = 0;
    r   = '0;
    for (int i = 0; i < N; i++) begin
      if (hang_idx == i) begin
        lat  += 1 + T;
        r.tmo = 1'b1;
        r.err = 1'b1;
        break;
      end
      addr_q.push_back(BASE + 32'(i));
      model_buf[i] = mem[i];
      if (slverr[i]) r.err = 1'b1;
      lat += 2 + waits[i];
    end
    r.cyc = 32'(c0 + lat + 1);
    for (int j = 0; j < 16; j++) r.b[j] = (j < N) ? model_buf[j] : 32'h0;
    res_q.push_back(r);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    for (int j = 0; j < 16; j++) model_buf[j] = '0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge pclk);
      #3;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (!got) begin
      do_reset();
      addr_q.delete();
      res_q.delete();
    end
  endtask

  task automatic run_one(input bit extra_start);
    @(negedge pclk);
    predict(cyc);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    if (extra_start) begin
      repeat (2) @(negedge pclk);
      start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    bit found;
    preset = 1'b1; start = 1'b0; hang_idx = -1;
    for (int j = 0; j < 16; j++) begin
      model_buf[j] = '0; waits[j] = 0; slverr[j] = 1'b0; mem[j] = '0;
    end
    repeat (3) @(negedge pclk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    preset = 1'b0;
    repeat (2) @(negedge pclk);

    cfg_clear();
    mem[0] = 32'hC90F_DAA2; mem[2] = 32'hADF8_5458;
    run_one(1'b0);

    cfg_clear();
    waits[1] = 3;
    run_one(1'b0);

    cfg_clear();
    hang_idx = 2;
    run_one(1'b0);

    cfg_clear();
    slverr[0] = 1'b1;
    run_one(1'b0);

    // Extra start while busy, and one more presented on the FIN cycle.
    cfg_clear();
    run_one(1'b1);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    repeat (6) @(negedge pclk);
    chk("fin_start_ignored", busy, 1'b0);

    // Reset while waiting in ACCESS of word 1.
    cfg_clear();
    hang_idx = 1;
    @(negedge pclk);
    addr_q.push_back(BASE);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge pclk);
      #3;
      if (psel && penable && paddr == BASE + 32'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_access1", 32'(found), 32'd1);
    preset = 1'b1;
    #1;
    chk("midrst_psel", psel, 1'b0);
    chk("midrst_penable", penable, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_paddr", paddr, 32'h0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    for (int j = 0; j < 16; j++) model_buf[j] = '0;
    repeat (5) @(negedge pclk);

    // Abort on word 0 leaves the whole buffer as reset left it.
    cfg_clear();
    hang_idx = 0;
    run_one(1'b0);

    for (int r = 0; r < 10; r++) begin
      cfg_clear();
      for (int i = 0; i < N; i++) begin
        waits[i]  = $urandom_range(0, 3);
        slverr[i] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 4) == 0) hang_idx = $urandom_range(0, N - 1);
      run_one(1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge pclk);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_rd_sequencer.md
Name: apb_rd_sequencer

Overview:
- Synthesizable APB3 read master; replaces the bench-driven read task in front of apb_slave.
- On a start pulse it issues P_NUM_WORDS back-to-back APB reads at P_BASE, P_BASE+1, ... (word-index addressing, step 1).
- Captures each prdata into an internal result buffer and raises done; err reports slave error or timeout.
- Sits between a local controller/CPU-side requester and the APB slave bus.

Parameters:
P_BASE, 32'h7000_0000, address of first read
P_NUM_WORDS, 4, number of consecutive reads per run (1..16)
P_TIMEOUT, 16, max ACCESS cycles waiting for pready before abort (>=1)

Ports:
pclk  in  1  APB clock, all logic on rising edge
preset  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a run
busy  out  1  high from the cycle after accepted start until done/abort
done  out  1  one-cycle pulse when run finishes (success or error)
err  out  1  sticky run status: pslverr seen or timeout; cleared on next accepted start
timeout  out  1  sticky: the run aborted on timeout; cleared on next accepted start
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  32  APB address
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
rd_idx  in  4  result-buffer read index
rd_data  out  32  combinational buf[rd_idx]; 0 if rd_idx >= P_NUM_WORDS

Behaviour:
- Interface: one clock, pclk; reset preset is asynchronous, active-high.
- Reset values, applied immediately on preset: state=IDLE; psel, penable, busy, done, err, timeout = 0; paddr=0; idx=0; timeout counter=0; every buffer entry=0.
- FSM states: IDLE, SETUP, ACCESS, FIN.
- IDLE: start=1 moves to SETUP and clears err, timeout and idx. start in any other state is ignored and does not queue.
- SETUP (one cycle): psel=1, penable=0, paddr=P_BASE+idx (32-bit wrap). Next state is ACCESS.
- ACCESS: psel=1, penable=1, paddr held stable. pready is sampled every cycle.
- On pready=1: buf[idx]<=prdata; if pslverr=1, err<=1 (data still stored, sequence continues). Then:
  - if idx==P_NUM_WORDS-1, go to FIN;
  - else idx++ and go to SETUP. psel stays high across the transition; penable drops for exactly one cycle.
- Timeout counter: clears on entering ACCESS and increments each ACCESS cycle with pready=0. On reaching P_TIMEOUT it aborts: err<=1, timeout<=1, go to FIN. Remaining buffer entries keep their prior values.
- FIN (one cycle): psel=0, penable=0, done=1, busy=0. Next state is IDLE. done is never asserted in any other state.
- busy=1 in SETUP and ACCESS.
- Latency with zero-wait slave: 2 cycles per word. done asserts 2*P_NUM_WORDS+1 cycles after the start edge.
- APB rules:
  - penable is never high without psel.
  - paddr changes only in SETUP.
  - no new transfer begins in the cycle pready is accepted.
- Reset mid-run: bus returns to idle immediately. No done pulse is issued. The buffer clears.
- start on the same edge as FIN→IDLE is ignored (accepted only in IDLE).

Test Plan:
- Reset then start, bench slave model zero-wait with pi/e words (idx0=0xC90FDAA2, idx2=0xADF85458) → paddr sequence 0x7000_0000..0x7000_0003; rd_data[0]=0xC90FDAA2, rd_data[2]=0xADF85458; done at cycle 9 after start; err=0.
- Slave inserts 3 wait states on idx1 → paddr/psel/penable held steady for 4 ACCESS cycles; capture only on the pready cycle; done at cycle 12.
- pready never asserts on idx2 with P_TIMEOUT=16 → abort after 16 ACCESS cycles; err=1, timeout=1, done pulse; buf[2], buf[3] unchanged; psel=0 next cycle.
- pslverr=1 with pready on idx0 → err=1, timeout=0; all 4 reads still complete; buffer holds returned data.
- start pulsed while busy, and preset asserted during ACCESS of idx1 → extra start ignored (4 transfers only); reset immediately drives psel=penable=busy=0, buffer all 0, no done pulse.
